sim_mem_arbiter: RTL

- Shares one behavioural-memory request/response channel between instruction-cache refills and data-cache miss reads in the simulation top.
- Holds the icache request in a skid register, because the icache issues single-cycle valid pulses with no ready.
- Arbitrates round-robin and caps outstanding transactions.
- Steers each response back to its source using a source bit prepended to the transaction ID.

---
 rtl/sim_mem_arbiter_if.sv | 64 ++++++
 rtl/sim_mem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_arbiter_if.sv
// Channel bundle for sim_mem_arbiter: icache refill, dcache miss-read and downstream memory ports.
// Stats outputs are present only when SIM_MEM_ARB_STATS_EN is defined.
interface sim_mem_arbiter_if #(
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 128,
  parameter int DC_ID_W = 4
);
  logic               ic_valid_i;
  logic [ADDR_W-1:0]  ic_addr_i;
  logic               ic_valid_o;
  logic [DATA_W-1:0]  ic_data_o;

  logic               dc_req_valid_i;
  logic               dc_req_ready_o;
  logic [ADDR_W-1:0]  dc_req_addr_i;
  logic [DC_ID_W-1:0] dc_req_id_i;
  logic               dc_resp_valid_o;
  logic               dc_resp_ready_i;
  logic [DATA_W-1:0]  dc_resp_data_o;
  logic [DC_ID_W-1:0] dc_resp_id_o;
  logic               dc_resp_last_o;

  logic               mem_req_valid_o;
  logic               mem_req_ready_i;
  logic [ADDR_W-1:0]  mem_req_addr_o;
  logic [DC_ID_W:0]   mem_req_id_o;
  logic               mem_resp_valid_i;
  logic               mem_resp_ready_o;
  logic [DATA_W-1:0]  mem_resp_data_i;
  logic [DC_ID_W:0]   mem_resp_id_i;
  logic               mem_resp_last_i;

`ifdef SIM_MEM_ARB_STATS_EN
  logic [31:0]        ic_grants_o;
  logic [31:0]        dc_grants_o;
  logic [31:0]        stall_cycles_o;
`endif

  // Arbiter side.
  modport master (
    input  ic_valid_i, ic_addr_i,
           dc_req_valid_i, dc_req_addr_i, dc_req_id_i, dc_resp_ready_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_id_i, mem_resp_last_i,
    output ic_valid_o, ic_data_o,
           dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o, dc_resp_id_o, dc_resp_last_o,
           mem_req_valid_o, mem_req_addr_o, mem_req_id_o, mem_resp_ready_o
`ifdef SIM_MEM_ARB_STATS_EN
    , output ic_grants_o, dc_grants_o, stall_cycles_o
`endif
  );

  // Cache/memory environment side.
  modport slave (
    output ic_valid_i, ic_addr_i,
           dc_req_valid_i, dc_req_addr_i, dc_req_id_i, dc_resp_ready_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_id_i, mem_resp_last_i,
    input  ic_valid_o, ic_data_o,
           dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o, dc_resp_id_o, dc_resp_last_o,
           mem_req_valid_o, mem_req_addr_o, mem_req_id_o, mem_resp_ready_o
`ifdef SIM_MEM_ARB_STATS_EN
    , input ic_grants_o, dc_grants_o, stall_cycles_o
`endif
  );
endinterface

// File: rtl/sim_mem_arbiter.sv
// Round-robin arbiter sharing one behavioural-memory channel between icache refills and dcache miss reads.
// Define SIM_MEM_ARB_STATS_EN to add saturating grant and stall counters.
module sim_mem_arbiter_chk (
  input logic tb_clk,
  input logic tb_rstn,
  input logic underflow
);
  // A last response with nothing outstanding means the memory model misbehaved.
  always @(posedge tb_clk) begin
    if (tb_rstn) begin
      assert (!underflow) else $error("sim_mem_arbiter: last response with no outstanding request");
    end
  end
endmodule

module sim_mem_arbiter #(
  parameter int ADDR_W          = 40,
  parameter int DATA_W          = 128,
  parameter int DC_ID_W         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               tb_clk,
  input logic               tb_rstn,
  sim_mem_arbiter_if.master bus
);
  localparam int         ID_W    = DC_ID_W + 1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_r;
  logic              ic_pend_r;
  logic [ADDR_W-1:0] ic_addr_r;
  logic              last_ic_r;
  logic              hold_ic_r;
  logic              mem_req_valid_r;
  logic [ADDR_W-1:0] mem_req_addr_r;
  logic [ID_W-1:0]   mem_req_id_r;
  logic [3:0]        cnt_r;
  logic              ic_valid_r;
  logic [DATA_W-1:0] ic_data_r;

  logic room_s, ic_cand_s, dc_cand_s, grant_ic_s, grant_dc_s;
  logic resp_ic_s, resp_ready_s, req_hs_s, resp_last_hs_s, underflow_s;

  // Grant selection and handshake decode; last_ic_r=1 means the dcache side wins a tie.
  always_comb begin
    room_s    = (cnt_r < MAX_CNT);
    ic_cand_s = (state_r == IDLE) && ic_pend_r && room_s;
    dc_cand_s = (state_r == IDLE) && bus.dc_req_valid_i && room_s;
    if (ic_cand_s && dc_cand_s) begin
      grant_ic_s = ~last_ic_r;
      grant_dc_s = last_ic_r;
    end else begin
      grant_ic_s = ic_cand_s;
      grant_dc_s = dc_cand_s;
    end
    resp_ic_s      = bus.mem_resp_id_i[ID_W-1];
    resp_ready_s   = resp_ic_s ? 1'b1 : bus.dc_resp_ready_i;
    req_hs_s       = mem_req_valid_r && bus.mem_req_ready_i;
    resp_last_hs_s = bus.mem_resp_valid_i && resp_ready_s && bus.mem_resp_last_i;
    underflow_s    = resp_last_hs_s && !req_hs_s && (cnt_r == 4'd0);
  end

  // Request FSM: grant in IDLE, then hold the downstream request stable until accepted.
  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      state_r         <= IDLE;
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= {ADDR_W{1'b0}};
      mem_req_id_r    <= {ID_W{1'b0}};
      hold_ic_r       <= 1'b0;
      last_ic_r       <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_ic_s || grant_dc_s) begin
            state_r         <= HOLD;
            mem_req_valid_r <= 1'b1;
            hold_ic_r       <= grant_ic_s;
            mem_req_addr_r  <= grant_ic_s ? ic_addr_r : bus.dc_req_addr_i;
            mem_req_id_r    <= grant_ic_s ? {1'b1, {DC_ID_W{1'b0}}} : {1'b0, bus.dc_req_id_i};
          end
        end
        HOLD: begin
          if (bus.mem_req_ready_i) begin
            state_r         <= IDLE;
            mem_req_valid_r <= 1'b0;
            last_ic_r       <= hold_ic_r;
          end
        end
        default: begin
          state_r         <= IDLE;
          mem_req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Icache skid register: a fresh pulse always wins, even over a same-cycle grant.
  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      ic_pend_r <= 1'b0;
      ic_addr_r <= {ADDR_W{1'b0}};
    end else if (bus.ic_valid_i) begin
      ic_pend_r <= 1'b1;
      ic_addr_r <= bus.ic_addr_i;
    end else if (grant_ic_s) begin
      ic_pend_r <= 1'b0;
    end
  end

  // Outstanding count: simultaneous issue and retire cancel; never wraps below zero.
  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      cnt_r <= 4'd0;
    end else if (req_hs_s && !resp_last_hs_s) begin
      cnt_r <= cnt_r + 4'd1;
    end else if (!req_hs_s && resp_last_hs_s && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Icache response: only the last beat of a refill is forwarded, one cycle later.
  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      ic_valid_r <= 1'b0;
      ic_data_r  <= {DATA_W{1'b0}};
    end else begin
      ic_valid_r <= resp_last_hs_s && resp_ic_s;
      if (resp_last_hs_s && resp_ic_s) begin
        ic_data_r <= bus.mem_resp_data_i;
      end
    end
  end

  assign bus.ic_valid_o       = ic_valid_r;
  assign bus.ic_data_o        = ic_data_r;
  assign bus.dc_req_ready_o   = tb_rstn && grant_dc_s;
  assign bus.dc_resp_valid_o  = tb_rstn && bus.mem_resp_valid_i && !resp_ic_s;
  assign bus.dc_resp_data_o   = tb_rstn ? bus.mem_resp_data_i : {DATA_W{1'b0}};
  assign bus.dc_resp_id_o     = tb_rstn ? bus.mem_resp_id_i[DC_ID_W-1:0] : {DC_ID_W{1'b0}};
  assign bus.dc_resp_last_o   = tb_rstn && bus.mem_resp_last_i;
  assign bus.mem_req_valid_o  = mem_req_valid_r;
  assign bus.mem_req_addr_o   = mem_req_addr_r;
  assign bus.mem_req_id_o     = mem_req_id_r;
  assign bus.mem_resp_ready_o = tb_rstn && resp_ready_s;

  sim_mem_arbiter_chk u_chk (
    .tb_clk    (tb_clk),
    .tb_rstn   (tb_rstn),
    .underflow (underflow_s)
  );

`ifdef SIM_MEM_ARB_STATS_EN
  logic [31:0] ic_grants_r;
  logic [31:0] dc_grants_r;
  logic [31:0] stall_cycles_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating grant and stall statistics.
  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      ic_grants_r    <= 32'd0;
      dc_grants_r    <= 32'd0;
      stall_cycles_r <= 32'd0;
    end else begin
      if (req_hs_s && hold_ic_r) begin
        ic_grants_r <= sat_inc(ic_grants_r);
      end
      if (req_hs_s && !hold_ic_r) begin
        dc_grants_r <= sat_inc(dc_grants_r);
      end
      if ((state_r == HOLD) && !bus.mem_req_ready_i) begin
        stall_cycles_r <= sat_inc(stall_cycles_r);
      end
    end
  end

  assign bus.ic_grants_o    = ic_grants_r;
  assign bus.dc_grants_o    = dc_grants_r;
  assign bus.stall_cycles_o = stall_cycles_r;
`endif
endmodule
